vector_csr_unit: RTL and testbench
==================================

VECTOR_CSR_UNIT -- requirements
Module: vector_csr_unit

Interface
REQ-001 SHALL have parameters XLEN, default 32, scalar data width; VLEN, default 256, vector register bits.
REQ-002 SHALL have clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  in  1; req_ready  out  1  request handshake.
REQ-005 SHALL have req_op  in  3  operation: 0 CSRRW, 1 CSRRS, 2 CSRRC, 3 VSETVL; 4-7 illegal.
REQ-006 SHALL have req_addr  in  12  CSR address, encoded as the package csr_regs enum.
REQ-007 SHALL have req_wdata  in  XLEN  CSR write operand, or AVL for VSETVL.
REQ-008 SHALL have req_vtype  in  XLEN  requested vtype for VSETVL.
REQ-009 SHALL have req_avlmax  in  1  VSETVL only: request vl=VLMAX, ignoring AVL.
REQ-010 SHALL have resp_valid  in/out: resp_valid out 1, resp_ready in 1  response handshake.
REQ-011 SHALL have resp_rdata  out  XLEN; resp_illegal  out  1.
REQ-012 SHALL have vl_o, vtype_o  out  XLEN; vstart_o  out  $clog2(VLEN); vxrm_o  out  2  live CSR state to the vector ALU/LSU.
REQ-013 SHALL have vxsat_set_i  in  1  saturation event from the ALU; vstart_clr_i  in  1  vector instruction retired.

Function
REQ-014 Request SHALL be accepted when req_valid && req_ready; req_ready = !resp_valid || resp_ready.
REQ-015 Accepted request SHALL update CSR state and load the response register on the same edge; resp_valid rises the next cycle (latency 1).
REQ-016 resp_valid, resp_rdata, resp_illegal SHALL hold stable until resp_valid && resp_ready; back-to-back accept permitted on the completing cycle.
REQ-017 CSRRW/RS/RC SHALL return the pre-update CSR value in resp_rdata; RS ORs, RC clears bits with req_wdata.
REQ-018 vcsr read value SHALL be {29'b0, vxrm[1:0], vxsat}; writes to vcsr update both fields.
REQ-019 vxrm writes SHALL use wdata[1:0]; vxsat writes wdata[0]; vstart writes wdata[$clog2(VLEN)-1:0]; upper bits ignored.
REQ-020 vlenb SHALL read VLEN/8 (32 at default).
REQ-021 CSRRW/RS/RC to vl, vtype, vlenb, or any non-enumerated address SHALL set resp_illegal=1, rdata=0, no state change; RS/RC with wdata=0 to read-only CSRs SHALL be legal reads.
REQ-022 req_op 4-7 SHALL respond illegal, no state change.
REQ-023 VSETVL vtype fields: vlmul=[2:0], vsew=[5:3], vta=[6], vma=[7]; SEW=8<<vsew.
REQ-024 vtype SHALL be ill if vsew>2, vlmul==4, or bits [XLEN-1:8] nonzero.
REQ-025 VLMAX = (VLEN>>(3+vsew)) << vlmul for vlmul 0-3; >> (8-vlmul) for vlmul 5-7.
REQ-026 Legal VSETVL: vtype<=req_vtype[7:0]; vl<=VLMAX if req_avlmax or AVL>VLMAX, else AVL; vstart<=0; rdata=new vl; resp_illegal=0.
REQ-027 Ill VSETVL: vtype<=32'h8000_0000, vl<=0, vstart<=0, rdata=0, resp_illegal=0.
REQ-028 vxsat_set_i SHALL set vxsat sticky; coincident with a CSR write to vxsat/vcsr, the set wins (final vxsat=1).
REQ-029 vstart_clr_i SHALL zero vstart; coincident with an accepted vstart write, the write wins.
REQ-030 Stalled response (resp_valid && !resp_ready) SHALL not block vxsat_set_i or vstart_clr_i.

Reset
REQ-031 rst_n low SHALL asynchronously force vl=0, vtype=32'h8000_0000, vstart=0, vxrm=0, vxsat=0, resp_valid=0, resp_rdata=0, resp_illegal=0.
REQ-032 Reset mid-transaction SHALL discard the pending response; req_ready=1 from the first cycle after deassertion.

Verification
REQ-033 VSETVL vtype=0x00 (SEW8, LMUL1), AVL=40 -> next cycle resp_valid, rdata=32, vl_o=32.
REQ-034 VSETVL vtype=0x13 (SEW32, LMUL8), req_avlmax=1 -> vl_o=64; then vtype=0x15 (SEW32, LMUL1/8) AVL=5 -> vl_o=1.
REQ-035 VSETVL vtype=0x18 (vsew=3) -> vtype_o=0x8000_0000, vl_o=0, resp_illegal=0.
REQ-036 CSRRW vcsr wdata=0x5 -> rdata=old vcsr, vxrm_o=2, vxsat=1; same cycle vxsat_set_i=1 with CSRRW vxsat wdata=0 -> vxsat=1.
REQ-037 CSRRW vl wdata=7 -> resp_illegal=1, vl_o unchanged; CSRRS vlenb wdata=0 -> rdata=32, legal.
REQ-038 Hold resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable, second request accepted only on release cycle.

Source files
------------

// File: rtl/vector_csr_unit.sv
// vector_csr_unit: vector CSR file (vstart/vxsat/vxrm/vcsr/vl/vtype/vlenb) with VSETVL and a registered response
package vector_csr_unit_pkg;
   typedef enum logic [11:0] {
      CSR_VSTART = 12'h008,
      CSR_VXSAT  = 12'h009,
      CSR_VXRM   = 12'h00A,
      CSR_VCSR   = 12'h00F,
      CSR_VL     = 12'hC20,
      CSR_VTYPE  = 12'hC21,
      CSR_VLENB  = 12'hC22
   } csr_regs;
endpackage

module vector_csr_unit
   import vector_csr_unit_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int VLEN = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [2:0]              req_op,
   input  logic [11:0]             req_addr,
   input  logic [XLEN-1:0]         req_wdata,
   input  logic [XLEN-1:0]         req_vtype,
   input  logic                    req_avlmax,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [XLEN-1:0]         resp_rdata,
   output logic                    resp_illegal,
   output logic [XLEN-1:0]         vl_o,
   output logic [XLEN-1:0]         vtype_o,
   output logic [$clog2(VLEN)-1:0] vstart_o,
   output logic [1:0]              vxrm_o,
   input  logic                    vxsat_set_i,
   input  logic                    vstart_clr_i
);
   localparam int VSW = $clog2(VLEN);
   localparam logic [XLEN-1:0] VILL = {1'b1, {(XLEN-1){1'b0}}};

   logic [XLEN-1:0] r_vl, r_vtype, r_rdata;
   logic [VSW-1:0]  r_vstart;
   logic [1:0]      r_vxrm;
   logic            r_vxsat, r_rvalid, r_illegal;
   logic            w_accept, w_csr, w_vset, w_ro, w_known, w_writes, w_legal, w_wr, w_vill;
   logic [XLEN-1:0] w_old, w_base, w_vlmax, w_vl_new;
   logic [VSW-1:0]  w_new;
   logic [2:0]      w_vsew, w_vlmul;

   assign req_ready = !r_rvalid || resp_ready;
   assign w_accept  = req_valid && req_ready;
   assign w_csr     = req_op < 3'd3;
   assign w_vset    = req_op == 3'd3;
   assign w_ro      = req_addr == CSR_VL || req_addr == CSR_VTYPE || req_addr == CSR_VLENB;
   assign w_known   = w_ro || req_addr == CSR_VSTART || req_addr == CSR_VXSAT ||
                      req_addr == CSR_VXRM || req_addr == CSR_VCSR;
   // set/clear with a zero mask is a pure read, which keeps read-only CSRs readable via RS/RC
   assign w_writes  = req_op == 3'd0 || req_wdata != '0;
   assign w_legal   = w_csr && w_known && !(w_ro && w_writes);
   assign w_wr      = w_accept && w_legal && w_writes;

   assign w_old = req_addr == CSR_VSTART ? XLEN'(r_vstart) :
                  req_addr == CSR_VXSAT  ? XLEN'(r_vxsat) :
                  req_addr == CSR_VXRM   ? XLEN'(r_vxrm) :
                  req_addr == CSR_VCSR   ? XLEN'({r_vxrm, r_vxsat}) :
                  req_addr == CSR_VL     ? r_vl :
                  req_addr == CSR_VTYPE  ? r_vtype :
                  req_addr == CSR_VLENB  ? XLEN'(VLEN / 8) : '0;

   // only the low VSW bits ever land in a writable CSR
   assign w_new = req_op == 3'd0 ? req_wdata[VSW-1:0] :
                  req_op == 3'd1 ? w_old[VSW-1:0] | req_wdata[VSW-1:0] :
                                   w_old[VSW-1:0] & ~req_wdata[VSW-1:0];

   assign w_vsew   = req_vtype[5:3];
   assign w_vlmul  = req_vtype[2:0];
   assign w_vill   = w_vsew > 3'd2 || w_vlmul == 3'd4 || |req_vtype[XLEN-1:8];
   assign w_base   = XLEN'(VLEN) >> (3 + w_vsew);
   assign w_vlmax  = w_vlmul[2] ? w_base >> (4'd8 - {1'b0, w_vlmul}) : w_base << w_vlmul[1:0];
   assign w_vl_new = req_avlmax || req_wdata > w_vlmax ? w_vlmax : req_wdata;

   // response register: load on accept, drop once consumed, otherwise hold stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_rvalid  <= 1'b1;
         r_rdata   <= w_vset ? (w_vill ? '0 : w_vl_new) : (w_legal ? w_old : '0);
         r_illegal <= !w_vset && !w_legal;
      end else if (resp_ready) begin
         r_rvalid  <= 1'b0;
      end
   end

   // CSR state: ALU saturation always sticks, an explicit vstart write beats the retire clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vl     <= '0;
         r_vtype  <= VILL;
         r_vstart <= '0;
         r_vxrm   <= 2'd0;
         r_vxsat  <= 1'b0;
      end else begin
         if (w_accept && w_vset) begin
            r_vtype <= w_vill ? VILL : {{(XLEN-8){1'b0}}, req_vtype[7:0]};
            r_vl    <= w_vill ? '0 : w_vl_new;
         end
         if (w_wr && req_addr == CSR_VXRM) r_vxrm <= w_new[1:0];
         else if (w_wr && req_addr == CSR_VCSR) r_vxrm <= w_new[2:1];
         r_vxsat <= vxsat_set_i || (w_wr && (req_addr == CSR_VXSAT || req_addr == CSR_VCSR) ? w_new[0] : r_vxsat);
         if (w_wr && req_addr == CSR_VSTART) r_vstart <= w_new;
         else if ((w_accept && w_vset) || vstart_clr_i) r_vstart <= '0;
      end
   end

   assign resp_valid   = r_rvalid;
   assign resp_rdata   = r_rdata;
   assign resp_illegal = r_illegal;
   assign vl_o         = r_vl;
   assign vtype_o      = r_vtype;
   assign vstart_o     = r_vstart;
   assign vxrm_o       = r_vxrm;
endmodule

// File: tb/tb_vector_csr_unit.sv
// tb_vector_csr_unit: directed and random requests scored against a behavioural CSR model
module tb_vector_csr_unit;
   localparam int XLEN = 32;
   localparam int VLEN = 256;
   localparam logic [11:0] A_VSTART = 12'h008, A_VXSAT = 12'h009, A_VXRM = 12'h00A, A_VCSR = 12'h00F;
   localparam logic [11:0] A_VL = 12'hC20, A_VTYPE = 12'hC21, A_VLENB = 12'hC22;

   typedef struct {
      logic [31:0] rdata;
      logic        ill;
   } rsp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid, req_ready, req_avlmax, resp_valid, resp_ready, resp_illegal, vxsat_set_i, vstart_clr_i;
   logic [2:0]  req_op;
   logic [11:0] req_addr;
   logic [31:0] req_wdata, req_vtype, resp_rdata, vl_o, vtype_o;
   logic [7:0]  vstart_o;
   logic [1:0]  vxrm_o;

   int n_cmp = 0, n_fail = 0;
   rsp_t q[$];
   logic [31:0] m_vl, m_vtype, m_vstart, m_vxrm, m_vxsat;
   bit m_rv, m_acc;
   logic [31:0] mon_rdata;
   logic        mon_ill;
   logic [11:0] addrs[8];

   vector_csr_unit #(.XLEN(XLEN), .VLEN(VLEN)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_vtype(req_vtype), .req_avlmax(req_avlmax),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
      .vl_o(vl_o), .vtype_o(vtype_o), .vstart_o(vstart_o), .vxrm_o(vxrm_o),
      .vxsat_set_i(vxsat_set_i), .vstart_clr_i(vstart_clr_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_vl = 0; m_vtype = 32'h8000_0000; m_vstart = 0; m_vxrm = 0; m_vxsat = 0; m_rv = 0;
      q.delete();
   endtask

   function automatic logic [31:0] rd(input logic [11:0] a);
      if (a == A_VSTART) return m_vstart;
      if (a == A_VXSAT)  return m_vxsat;
      if (a == A_VXRM)   return m_vxrm;
      if (a == A_VCSR)   return m_vxrm * 2 + m_vxsat;
      if (a == A_VL)     return m_vl;
      if (a == A_VTYPE)  return m_vtype;
      if (a == A_VLENB)  return 32'(VLEN / 8);
      return 0;
   endfunction

   // what the next rising edge does, given the inputs currently applied
   task automatic model_edge();
      logic [31:0] old, nv, vlmax;
      bit writes, known, ro, wrote_vs;
      int sew, num, den;
      rsp_t r;
      m_acc = req_valid && (!m_rv || resp_ready);
      m_rv = m_acc || (m_rv && !resp_ready);
      wrote_vs = 0;
      if (m_acc) begin
         r.rdata = 0;
         r.ill = 0;
         if (req_op == 3) begin
            if (req_vtype[5:3] > 2 || req_vtype[2:0] == 4 || req_vtype[31:8] != 0) begin
               m_vtype = 32'h8000_0000;
               m_vl = 0;
            end else begin
               sew = 8 << req_vtype[5:3];
               num = req_vtype[2] ? 1 : 1 << req_vtype[1:0];
               den = req_vtype[2] ? 1 << (8 - req_vtype[2:0]) : 1;
               vlmax = 32'(VLEN * num / (sew * den));
               m_vl = (req_avlmax || req_wdata > vlmax) ? vlmax : req_wdata;
               m_vtype = {24'b0, req_vtype[7:0]};
               r.rdata = m_vl;
            end
            m_vstart = 0;
         end else if (req_op < 3) begin
            ro = req_addr inside {A_VL, A_VTYPE, A_VLENB};
            known = ro || req_addr inside {A_VSTART, A_VXSAT, A_VXRM, A_VCSR};
            writes = req_op == 0 || req_wdata != 0;
            if (!known || (ro && writes)) r.ill = 1;
            else begin
               old = rd(req_addr);
               r.rdata = old;
               nv = req_op == 0 ? req_wdata : req_op == 1 ? old | req_wdata : old & ~req_wdata;
               if (writes) begin
                  if (req_addr == A_VSTART) begin m_vstart = nv % VLEN; wrote_vs = 1; end
                  if (req_addr == A_VXSAT) m_vxsat = nv & 1;
                  if (req_addr == A_VXRM) m_vxrm = nv & 3;
                  if (req_addr == A_VCSR) begin m_vxrm = (nv >> 1) & 3; m_vxsat = nv & 1; end
               end
            end
         end else r.ill = 1;
         q.push_back(r);
      end
      if (vxsat_set_i) m_vxsat = 1;
      if (vstart_clr_i && !wrote_vs) m_vstart = 0;
   endtask

   // one clock: check live state at negedge, advance the model, return just after posedge
   task automatic step();
      @(negedge clk);
      #1;
      chk("vl_o", vl_o, m_vl);
      chk("vtype_o", vtype_o, m_vtype);
      chk("vstart_o", 32'(vstart_o), m_vstart);
      chk("vxrm_o", 32'(vxrm_o), m_vxrm);
      chk("resp_valid", 32'(resp_valid), 32'(m_rv));
      chk("req_ready", 32'(req_ready), 32'(!m_rv || resp_ready));
      if (rst_n) model_edge();
      else m_acc = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd, input logic [31:0] vt,
                        input logic amax, input logic sat, input logic clr);
      req_valid = 1; req_op = op; req_addr = a; req_wdata = wd; req_vtype = vt; req_avlmax = amax;
      resp_ready = 1; vxsat_set_i = sat; vstart_clr_i = clr;
      m_acc = 0;
      for (int i = 0; i < 20 && !m_acc; i++) step();
      chk("issue_accepted", 32'(m_acc), 1);
      req_valid = 0; vxsat_set_i = 0; vstart_clr_i = 0;
      step();
   endtask

   // scoreboard monitor: presented response must match the oldest expectation every cycle it is held
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && resp_valid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL resp_unexpected: got rdata %h with no expectation at %0t", resp_rdata, $time);
            end else begin
               chk("resp_rdata", resp_rdata, q[0].rdata);
               chk("resp_illegal", 32'(resp_illegal), 32'(q[0].ill));
               mon_rdata = resp_rdata;
               mon_ill = resp_illegal;
               if (resp_ready) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      addrs = '{A_VSTART, A_VXSAT, A_VXRM, A_VCSR, A_VL, A_VTYPE, A_VLENB, 12'h000};
      req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_vtype = 0; req_avlmax = 0;
      resp_ready = 0; vxsat_set_i = 0; vstart_clr_i = 0;
      mon_rdata = 0; mon_ill = 0;
      model_reset();
      step();
      step();
      rst_n = 1;
      step();
      issue(3, 0, 40, 32'h00, 0, 0, 0);
      chk("d_sew8_rdata", mon_rdata, 32);
      chk("d_sew8_vl", vl_o, 32);
      issue(3, 0, 0, 32'h13, 1, 0, 0);
      chk("d_lmul8_vl", vl_o, 64);
      issue(3, 0, 5, 32'h15, 0, 0, 0);
      chk("d_frac_vl", vl_o, 1);
      issue(0, A_VL, 7, 0, 0, 0, 0);
      chk("d_vl_wr_ill", 32'(mon_ill), 1);
      chk("d_vl_wr_rdata", mon_rdata, 0);
      chk("d_vl_unchanged", vl_o, 1);
      issue(1, A_VLENB, 0, 0, 0, 0, 0);
      chk("d_vlenb_rdata", mon_rdata, 32);
      chk("d_vlenb_legal", 32'(mon_ill), 0);
      issue(2, A_VTYPE, 1, 0, 0, 0, 0);
      chk("d_vtype_rc_ill", 32'(mon_ill), 1);
      issue(3, 0, 10, 32'h18, 0, 0, 0);
      chk("d_vill_vtype", vtype_o, 32'h8000_0000);
      chk("d_vill_vl", vl_o, 0);
      chk("d_vill_legal", 32'(mon_ill), 0);
      issue(7, A_VCSR, 3, 0, 0, 0, 0);
      chk("d_badop_ill", 32'(mon_ill), 1);
      issue(0, A_VCSR, 5, 0, 0, 0, 0);
      chk("d_vcsr_old", mon_rdata, 0);
      chk("d_vcsr_vxrm", 32'(vxrm_o), 2);
      issue(0, A_VXSAT, 0, 0, 0, 1, 0);
      chk("d_sat_wr_old", mon_rdata, 1);
      issue(1, A_VCSR, 0, 0, 0, 0, 0);
      chk("d_sat_wins", mon_rdata, 5);
      issue(0, A_VSTART, 32'h1_09, 0, 0, 0, 1);
      chk("d_vstart_wr_wins", 32'(vstart_o), 9);
      vstart_clr_i = 1;
      step();
      vstart_clr_i = 0;
      chk("d_vstart_clr", 32'(vstart_o), 0);
      req_valid = 1; req_op = 1; req_addr = A_VLENB; req_wdata = 0; resp_ready = 1;
      step();
      req_op = 3; req_addr = 0; req_wdata = 7; req_vtype = 0; req_avlmax = 0; resp_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("d_stall_ready", 32'(req_ready), 0);
         chk("d_stall_hold", resp_rdata, 32);
      end
      resp_ready = 1;
      step();
      chk("d_release_accept", 32'(m_acc), 1);
      req_valid = 0;
      step();
      chk("d_release_rdata", mon_rdata, 7);
      chk("d_release_vl", vl_o, 7);
      req_valid = 1; req_op = 0; req_addr = A_VXRM; req_wdata = 1;
      step();
      req_valid = 0; resp_ready = 0;
      #2;
      rst_n = 0;
      #1;
      chk("r_async_valid", 32'(resp_valid), 0);
      chk("r_async_rdata", resp_rdata, 0);
      chk("r_async_vtype", vtype_o, 32'h8000_0000);
      chk("r_async_vxrm", 32'(vxrm_o), 0);
      model_reset();
      step();
      rst_n = 1;
      step();
      chk("r_ready_after", 32'(req_ready), 1);
      for (int c = 0; c < 1500; c++) begin
         req_valid = $urandom_range(0, 9) < 7;
         resp_ready = $urandom_range(0, 9) < 7;
         req_op = $urandom_range(0, 19) < 13 ? 3'($urandom_range(0, 2)) :
                  $urandom_range(0, 5) > 0 ? 3'd3 : 3'($urandom_range(4, 7));
         req_addr = addrs[$urandom_range(0, 7)];
         if (req_addr == 12'h000) req_addr = 12'($urandom);
         req_wdata = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 1) ? $urandom : $urandom_range(0, 300);
         req_vtype = $urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 255);
         req_avlmax = $urandom_range(0, 3) == 0;
         vxsat_set_i = $urandom_range(0, 9) == 0;
         vstart_clr_i = $urandom_range(0, 9) == 0;
         step();
      end
      req_valid = 0; resp_ready = 1; vxsat_set_i = 0; vstart_clr_i = 0;
      for (int i = 0; i < 3; i++) step();
      chk("sb_drained", 32'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
